// File: rtl/div_sequencer.sv
// div_sequencer: EX-stage sequencer for RV32M DIV/DIVU/REM/REMU.
// Stalls the pipeline while an external unsigned 32-bit divider works on
// operand magnitudes, then sign-corrects the result and returns it for one
// cycle on div_out/div_done. Divide-by-zero and signed overflow are resolved
// locally without touching the divider.
// Ports:
//   CLK, rst                  clock, asynchronous active-high reset
//   div_valid, div_op         EX request and opcode (0 DIV,1 DIVU,2 REM,3 REMU)
//   opA, opB                  dividend, divisor
//   flush                     EX instruction killed this cycle
//   div_stall                 combinational pipeline hold for this cycle
//   div_out, div_done         result and its one-cycle strobe
//   ip_s_tvalid/tready        operand handshake to the divider
//   ip_dividend, ip_divisor   operand magnitudes to the divider
//   ip_m_tvalid/tready        result handshake from the divider
//   ip_quotient, ip_remainder unsigned divider result
module div_sequencer (
   input  logic        CLK,
   input  logic        rst,
   input  logic        div_valid,
   input  logic [1:0]  div_op,
   input  logic [31:0] opA,
   input  logic [31:0] opB,
   input  logic        flush,
   output logic        div_stall,
   output logic [31:0] div_out,
   output logic        div_done,
   output logic        ip_s_tvalid,
   input  logic        ip_s_tready,
   output logic [31:0] ip_dividend,
   output logic [31:0] ip_divisor,
   input  logic        ip_m_tvalid,
   output logic        ip_m_tready,
   input  logic [31:0] ip_quotient,
   input  logic [31:0] ip_remainder
);

   localparam int unsigned W = 32;
   localparam logic [W-1:0] INT_MIN  = 32'h8000_0000;
   localparam logic [W-1:0] ALL_ONES = 32'hFFFF_FFFF;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]   state, state_nxt;
   logic         killed, killed_nxt;
   logic         is_rem, is_rem_nxt;
   logic         neg_q, neg_q_nxt;
   logic         neg_r, neg_r_nxt;
   logic [W-1:0] div_out_nxt, dividend_nxt, divisor_nxt;
   logic         div_done_nxt, s_tvalid_nxt, m_tready_nxt;

   // Request decode: DIV/REM are the signed ops (op[0]=0), REM/REMU select remainder (op[1]=1)
   logic         req_signed, req_rem, div_zero, overflow, accept, busy;
   logic [W-1:0] mag_a, mag_b, special_res, raw_res, fixed_res;

   assign req_signed = ~div_op[0];
   assign req_rem    = div_op[1];
   assign mag_a      = (req_signed && opA[W-1]) ? (~opA + W'(1)) : opA;
   assign mag_b      = (req_signed && opB[W-1]) ? (~opB + W'(1)) : opB;
   assign div_zero   = (opB == '0);
   assign overflow   = req_signed && (opA == INT_MIN) && (opB == ALL_ONES);

   // Divide-by-zero wins over overflow; overflow only exists for signed ops
   assign special_res = div_zero ? (req_rem ? opA : ALL_ONES)
                                 : (req_rem ? '0  : INT_MIN);

   // Sign correction of the unsigned divider result
   assign raw_res   = is_rem ? ip_remainder : ip_quotient;
   assign fixed_res = (is_rem ? neg_r : neg_q) ? (~raw_res + W'(1)) : raw_res;

   assign accept = (state == S_IDLE) && div_valid && !flush;
   assign busy   = (state == S_ISSUE) || (state == S_WAIT);

   // Stall is needed in the same cycle the request appears, so it is combinational
   assign div_stall = !rst && (accept
                               || (busy && !killed && !flush)
                               || (busy && killed && div_valid));

   // Next-state and registered-output logic
   always_comb begin
      state_nxt    = state;
      killed_nxt   = killed;
      is_rem_nxt   = is_rem;
      neg_q_nxt    = neg_q;
      neg_r_nxt    = neg_r;
      dividend_nxt = ip_dividend;
      divisor_nxt  = ip_divisor;
      div_out_nxt  = div_out;

      case (state)
         S_IDLE: begin
            if (div_valid && !flush) begin
               is_rem_nxt   = req_rem;
               neg_q_nxt    = req_signed && (opA[W-1] ^ opB[W-1]);
               neg_r_nxt    = req_signed && opA[W-1];
               dividend_nxt = mag_a;
               divisor_nxt  = mag_b;
               killed_nxt   = 1'b0;
               if (div_zero || overflow) begin
                  div_out_nxt = special_res;
                  state_nxt   = S_DONE;
               end else begin
                  state_nxt = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            // Operands stay presented until accepted even if the instruction dies
            killed_nxt = killed || flush;
            if (ip_s_tready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            killed_nxt = killed || flush;
            if (ip_m_tvalid) begin
               // A flush landing on the result cycle also discards the result
               if (killed || flush) begin
                  state_nxt  = S_IDLE;
                  killed_nxt = 1'b0;
               end else begin
                  div_out_nxt = fixed_res;
                  state_nxt   = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      div_done_nxt = (state_nxt == S_DONE);
      s_tvalid_nxt = (state_nxt == S_ISSUE);
      m_tready_nxt = (state_nxt == S_WAIT);
   end

   // State and output registers
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         killed      <= 1'b0;
         is_rem      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         div_out     <= '0;
         div_done    <= 1'b0;
         ip_s_tvalid <= 1'b0;
         ip_m_tready <= 1'b0;
         ip_dividend <= '0;
         ip_divisor  <= '0;
      end else begin
         state       <= state_nxt;
         killed      <= killed_nxt;
         is_rem      <= is_rem_nxt;
         neg_q       <= neg_q_nxt;
         neg_r       <= neg_r_nxt;
         div_out     <= div_out_nxt;
         div_done    <= div_done_nxt;
         ip_s_tvalid <= s_tvalid_nxt;
         ip_m_tready <= m_tready_nxt;
         ip_dividend <= dividend_nxt;
         ip_divisor  <= divisor_nxt;
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: scoreboard bench for div_sequencer.
// A driver issues RV32M divide requests (directed, then random) and pushes
// the expected result; a monitor pops and compares on every div_done. A
// behavioural unsigned divider answers the IP handshake with random delays
// and checks the operand magnitudes it receives.
module tb_div_sequencer;

   logic        CLK;
   logic        rst;
   logic        div_valid;
   logic [1:0]  div_op;
   logic [31:0] opA, opB;
   logic        flush;
   logic        div_stall;
   logic [31:0] div_out;
   logic        div_done;
   logic        ip_s_tvalid, ip_s_tready;
   logic [31:0] ip_dividend, ip_divisor;
   logic        ip_m_tvalid, ip_m_tready;
   logic [31:0] ip_quotient, ip_remainder;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];
   logic [63:0] ip_exp[$];
   int          fix_rdy = -1;
   int          fix_lat = -1;

   div_sequencer dut (
      .CLK(CLK), .rst(rst),
      .div_valid(div_valid), .div_op(div_op), .opA(opA), .opB(opB), .flush(flush),
      .div_stall(div_stall), .div_out(div_out), .div_done(div_done),
      .ip_s_tvalid(ip_s_tvalid), .ip_s_tready(ip_s_tready),
      .ip_dividend(ip_dividend), .ip_divisor(ip_divisor),
      .ip_m_tvalid(ip_m_tvalid), .ip_m_tready(ip_m_tready),
      .ip_quotient(ip_quotient), .ip_remainder(ip_remainder)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic void check(input bit ok, input string name,
                                 input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endfunction

   // RV32M semantics computed with 64-bit integer arithmetic
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, ua, ub, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      case (op)
         2'd0:    r = sa / sb;
         2'd1:    r = ua / ub;
         2'd2:    r = sa % sb;
         default: r = ua % ub;
      endcase
      return r[31:0];
   endfunction

   function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
      return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Operands the divider should see: absolute values for signed ops
   function automatic logic [63:0] ip_pair(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb;
      if (op[0]) return {a, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sa < 0) sa = -sa;
      if (sb < 0) sb = -sb;
      return {sa[31:0], sb[31:0]};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         4:       return 32'd0 - 32'($urandom_range(1, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic check_all_zero(input string tag);
      check(div_stall === 1'b0,    {tag, "_stall"},    32'(div_stall),   32'd0);
      check(div_done === 1'b0,     {tag, "_done"},     32'(div_done),    32'd0);
      check(ip_s_tvalid === 1'b0,  {tag, "_s_tvalid"}, 32'(ip_s_tvalid), 32'd0);
      check(ip_m_tready === 1'b0,  {tag, "_m_tready"}, 32'(ip_m_tready), 32'd0);
      check(div_out === 32'd0,     {tag, "_div_out"},  div_out,          32'd0);
      check(ip_dividend === 32'd0, {tag, "_dividend"}, ip_dividend,      32'd0);
      check(ip_divisor === 32'd0,  {tag, "_divisor"},  ip_divisor,       32'd0);
   endtask

   // Issue one instruction and hold it in EX until div_done
   task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit fresh);
      int n;
      bit stall_ok, saw_sv;
      n = 0; stall_ok = 1'b1; saw_sv = 1'b0;
      div_valid = 1'b1; div_op = op; opA = a; opB = b;
      exp_q.push_back(ref_result(op, a, b));
      if (!is_special(op, a, b)) ip_exp.push_back(ip_pair(op, a, b));
      if (div_done) @(negedge CLK);
      #1;
      if (div_stall !== 1'b1) stall_ok = 1'b0;
      while (n < 400) begin
         @(negedge CLK);
         n++;
         if (ip_s_tvalid) saw_sv = 1'b1;
         if (div_done) break;
         if (div_stall !== 1'b1) stall_ok = 1'b0;
      end
      check(div_done === 1'b1, "done_timeout", 32'(n), 32'd400);
      check(stall_ok, "stall_until_done", 32'(stall_ok), 32'd1);
      if (fresh && is_special(op, a, b)) begin
         check(n == 1, "special_latency", 32'(n), 32'd1);
         check(!saw_sv, "special_no_ip", 32'(saw_sv), 32'd0);
      end
      div_valid = 1'b0;
   endtask

   // Issue one instruction, then flush it while it sits in ISSUE or WAIT
   task automatic flush_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit in_wait);
      int n;
      n = 0;
      fix_rdy = in_wait ? 0 : 3;
      fix_lat = 4;
      div_valid = 1'b1; div_op = op; opA = a; opB = b;
      ip_exp.push_back(ip_pair(op, a, b));
      if (div_done) @(negedge CLK);
      do begin
         @(negedge CLK);
         n++;
      end while (!(in_wait ? ip_m_tready : ip_s_tvalid) && n < 50);
      check(n < 50, in_wait ? "reach_wait" : "reach_issue", 32'(n), 32'd50);
      flush = 1'b1;
      #1;
      check(div_stall === 1'b0, "flush_stall", 32'(div_stall), 32'd0);
      @(negedge CLK);
      flush = 1'b0;
      div_valid = 1'b0;
      fix_rdy = -1;
      fix_lat = -1;
   endtask

   // Behavioural unsigned divider with handshake delays
   initial begin
      int st, cnt;
      logic [31:0] dd, dv;
      logic [63:0] e;
      bit pres_rdy;
      st = 0; cnt = 0; dd = 0; dv = 0; pres_rdy = 1'b0;
      ip_s_tready = 1'b0; ip_m_tvalid = 1'b0; ip_quotient = 0; ip_remainder = 0;
      forever begin
         @(negedge CLK);
         if (rst) begin
            st = 0; ip_s_tready = 1'b0; ip_m_tvalid = 1'b0;
         end else begin
            case (st)
               0: if (ip_s_tvalid) begin
                     if (ip_exp.size() == 0) begin
                        check(1'b0, "ip_unexpected_req", ip_dividend, 32'd0);
                        e = {ip_dividend, ip_divisor};
                     end else begin
                        e = ip_exp.pop_front();
                     end
                     check(ip_dividend === e[63:32], "ip_dividend", ip_dividend, e[63:32]);
                     check(ip_divisor === e[31:0], "ip_divisor", ip_divisor, e[31:0]);
                     dd = ip_dividend; dv = ip_divisor;
                     cnt = (fix_rdy >= 0) ? fix_rdy : int'($urandom_range(0, 3));
                     if (cnt == 0) begin ip_s_tready = 1'b1; st = 2; end
                     else st = 1;
                  end
               1: begin
                     check(ip_s_tvalid === 1'b1 && ip_dividend === dd && ip_divisor === dv,
                           "ip_s_hold", 32'(ip_s_tvalid), 32'd1);
                     cnt--;
                     if (cnt == 0) begin ip_s_tready = 1'b1; st = 2; end
                  end
               2: begin
                     ip_s_tready = 1'b0;
                     check(ip_s_tvalid === 1'b0 && ip_m_tready === 1'b1, "ip_accept",
                           {30'd0, ip_s_tvalid, ip_m_tready}, 32'd1);
                     cnt = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 6));
                     st = 3;
                  end
               3: if (cnt > 0) cnt--;
               default: begin
                     if (pres_rdy) begin ip_m_tvalid = 1'b0; st = 0; end
                     else pres_rdy = ip_m_tready;
                  end
            endcase
            if (st == 3 && cnt == 0) begin
               ip_m_tvalid  = 1'b1;
               ip_quotient  = (dv == 0) ? 32'hFFFF_FFFF : dd / dv;
               ip_remainder = (dv == 0) ? dd : dd % dv;
               pres_rdy     = ip_m_tready;
               st = 4;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every result strobe
   initial begin
      bit prev;
      logic [31:0] e;
      prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (!rst && div_done) begin
            check(!prev, "done_pulse", 32'd2, 32'd1);
            check(div_stall === 1'b0, "done_stall", 32'(div_stall), 32'd0);
            if (exp_q.size() == 0) check(1'b0, "unexpected_done", div_out, 32'd0);
            else begin
               e = exp_q.pop_front();
               check(div_out === e, "div_out", div_out, e);
            end
         end
         prev = div_done && !rst;
      end
   end

   // Stimulus
   initial begin
      int n;
      logic [1:0]  op;
      logic [31:0] a, b;
      bit fl;
      rst = 1'b1; div_valid = 1'b0; div_op = 0; opA = 0; opB = 0; flush = 1'b0;
      repeat (3) @(negedge CLK);
      div_valid = 1'b1; opA = 32'd5; opB = 32'd1;
      #1;
      check_all_zero("reset");
      div_valid = 1'b0;
      rst = 1'b0;
      @(negedge CLK);

      fix_rdy = 1; fix_lat = 5;
      run_div(2'd1, 32'd100, 32'd7, 1'b1);
      fix_rdy = -1; fix_lat = -1;
      run_div(2'd0, 32'hFFFF_FFF9, 32'd2, 1'b1);
      run_div(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
      run_div(2'd0, 32'h0000_1234, 32'd0, 1'b1);
      run_div(2'd3, 32'd5, 32'd0, 1'b1);
      run_div(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      run_div(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

      flush_div(2'd0, 32'd1000, 32'd7, 1'b1);
      run_div(2'd0, 32'hFFFF_FF9C, 32'd9, 1'b0);
      flush_div(2'd2, 32'd77, 32'hFFFF_FFFB, 1'b0);
      run_div(2'd2, 32'd77, 32'hFFFF_FFFB, 1'b0);

      // Asynchronous reset while the divider is busy
      fix_rdy = 0; fix_lat = 8;
      div_valid = 1'b1; div_op = 2'd1; opA = 32'd50; opB = 32'd5;
      ip_exp.push_back(ip_pair(2'd1, 32'd50, 32'd5));
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!ip_m_tready && n < 50);
      check(n < 50, "reach_wait_rst", 32'(n), 32'd50);
      #2 rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      div_valid = 1'b0; fix_rdy = -1; fix_lat = -1;
      repeat (2) @(negedge CLK);
      exp_q.delete();
      ip_exp.delete();
      rst = 1'b0;
      @(negedge CLK);
      run_div(2'd1, 32'd9, 32'd3, 1'b1);

      run_div(2'd0, 32'd6, 32'd3, 1'b1);
      run_div(2'd0, 32'd8, 32'd2, 1'b1);

      for (int i = 0; i < 120; i++) begin
         op = 2'($urandom_range(0, 3));
         a = pick();
         b = pick();
         fl = 1'b0;
         if ($urandom_range(0, 7) == 0 && !is_special(op, a, b)) begin
            flush_div(op, a, b, 1'($urandom_range(0, 1)));
            fl = 1'b1;
            op = 2'($urandom_range(0, 3));
            a = pick();
         end
         run_div(op, a, b, !fl);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
      end

      repeat (10) @(negedge CLK);
      check(exp_q.size() == 0, "results_left", 32'(exp_q.size()), 32'd0);
      check(ip_exp.size() == 0, "ip_reqs_left", 32'(ip_exp.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
